fetch_mem_responder: RTL and testbench

- Memory-side responder for the fetch stage's instruction request interface.
- Accepts fetch requests (address plus MMU mode) and forwards them to the instruction memory/cache port.
- Tracks outstanding requests and buffers returned instructions so none are lost. Presents them back in order, honouring the fetch stage's lock.
- Discards responses belonging to requests issued before a flush (exception or branch-predict redirect).

---
 rtl/fetch_mem_responder_pkg.sv | 26 ++
 rtl/fetch_mem_responder_if.sv | 44 ++++
 rtl/fetch_mem_responder_sync_fifo.sv | 55 +++++
 rtl/fetch_mem_responder.sv | 110 +++++++++++
 tb/tb_fetch_mem_responder.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_mem_responder_pkg.sv
// Shared definitions for the fetch-side instruction memory responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: MMU mode encodings, MMU flag width, return-bundle layout (47 bits).
package fetch_mem_responder_pkg;

   localparam int MMU_FLAGS_W = 14;
   localparam int INST_W      = 32;
   localparam int RET_W       = 1 + MMU_FLAGS_W + INST_W;

   // MMU mode travelling with each fetch request; the responder only passes it through.
   typedef enum logic [1:0] {
      MMUMOD_NONE = 2'd0,   // translation off
      MMUMOD_L1   = 2'd1,   // single-level translation
      MMUMOD_L2   = 2'd2,   // two-level translation
      MMUMOD_RSVD = 2'd3
   } mmuMod_e;

   // One returned instruction as held in the return buffer.
   typedef struct packed {
      logic                   pageFault;
      logic [MMU_FLAGS_W-1:0] mmuFlags;
      logic [INST_W-1:0]      inst;
   } retBundle_t;

endpackage

// File: rtl/fetch_mem_responder_if.sv
// Bundles the fetch-stage and memory-side signals of the responder.
// Latency: n/a (wiring only).
// Backpressure: oFETCH_LOCK towards the fetch stage, iMEM_BUSY from memory, iINST_LOCK from the fetch stage.
// Modports: slave = responder view, master = environment (fetch stage + memory) view.
interface fetch_mem_responder_if;
   import fetch_mem_responder_pkg::*;

   logic                   iFLUSH;
   // fetch stage request side
   logic                   iFETCH_REQ;
   logic                   oFETCH_LOCK;
   mmuMod_e                iFETCH_MMUMOD;
   logic [31:0]            iFETCH_ADDR;
   // fetch stage return side
   logic                   oINST_VALID;
   logic                   oINST_PAGEFAULT;
   logic [MMU_FLAGS_W-1:0] oINST_MMU_FLAGS;
   logic [INST_W-1:0]      oINST;
   logic                   iINST_LOCK;
   // memory side
   logic                   oMEM_REQ;
   logic                   iMEM_BUSY;
   mmuMod_e                oMEM_MMUMOD;
   logic [31:0]            oMEM_ADDR;
   logic                   iMEM_VALID;
   logic                   iMEM_PAGEFAULT;
   logic [MMU_FLAGS_W-1:0] iMEM_MMU_FLAGS;
   logic [INST_W-1:0]      iMEM_DATA;

   modport slave (
      input  iFLUSH, iFETCH_REQ, iFETCH_MMUMOD, iFETCH_ADDR, iINST_LOCK,
             iMEM_BUSY, iMEM_VALID, iMEM_PAGEFAULT, iMEM_MMU_FLAGS, iMEM_DATA,
      output oFETCH_LOCK, oINST_VALID, oINST_PAGEFAULT, oINST_MMU_FLAGS, oINST,
             oMEM_REQ, oMEM_MMUMOD, oMEM_ADDR
   );

   modport master (
      output iFLUSH, iFETCH_REQ, iFETCH_MMUMOD, iFETCH_ADDR, iINST_LOCK,
             iMEM_BUSY, iMEM_VALID, iMEM_PAGEFAULT, iMEM_MMU_FLAGS, iMEM_DATA,
      input  oFETCH_LOCK, oINST_VALID, oINST_PAGEFAULT, oINST_MMU_FLAGS, oINST,
             oMEM_REQ, oMEM_MMUMOD, oMEM_ADDR
   );

endinterface

// File: rtl/fetch_mem_responder_sync_fifo.sv
// Synchronous FIFO with a whole-buffer clear (iREMOVE).
// Latency: write to readable head 1 cycle; read data is the combinational head.
// Backpressure: writes while oWR_FULL and reads while oRD_EMPTY are ignored.
// Ports: iWR_EN/iWR_DATA/oWR_FULL write side, iRD_EN/oRD_DATA/oRD_EMPTY read side, oCOUNT occupancy.
module fetch_mem_responder_sync_fifo #(
   parameter int P_N       = 47,
   parameter int P_DEPTH   = 4,
   parameter int P_DEPTH_N = 2
)(
   input  logic                 iCLOCK,
   input  logic                 inRESET,
   input  logic                 iREMOVE,
   input  logic                 iWR_EN,
   input  logic [P_N-1:0]       iWR_DATA,
   output logic                 oWR_FULL,
   input  logic                 iRD_EN,
   output logic [P_N-1:0]       oRD_DATA,
   output logic                 oRD_EMPTY,
   output logic [P_DEPTH_N:0]   oCOUNT
);

   logic [P_N-1:0]     mem [P_DEPTH];
   // One extra pointer bit separates full from empty.
   logic [P_DEPTH_N:0] wrPtr;
   logic [P_DEPTH_N:0] rdPtr;
   logic               wrFire;
   logic               rdFire;

   assign oCOUNT    = wrPtr - rdPtr;
   assign oRD_EMPTY = (wrPtr == rdPtr);
   // Depth is a power of two, so the count MSB is set exactly when full.
   assign oWR_FULL  = oCOUNT[P_DEPTH_N];
   assign oRD_DATA  = mem[rdPtr[P_DEPTH_N-1:0]];

   assign wrFire = iWR_EN && !oWR_FULL && !iREMOVE;
   assign rdFire = iRD_EN && !oRD_EMPTY && !iREMOVE;

   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else if (iREMOVE) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else begin
         if (wrFire) wrPtr <= wrPtr + 1'b1;
         if (rdFire) rdPtr <= rdPtr + 1'b1;
      end
   end

   always_ff @(posedge iCLOCK) begin
      if (wrFire) mem[wrPtr[P_DEPTH_N-1:0]] <= iWR_DATA;
   end

endmodule

// File: rtl/fetch_mem_responder.sv
// Forwards fetch requests to instruction memory and returns the responses in order, dropping pre-flush ones.
// Latency: request to memory combinational; memory response to oINST_VALID 1 cycle minimum.
// Backpressure: oFETCH_LOCK when memory is busy or in-flight + buffered reaches P_RETURN_DEPTH; iINST_LOCK holds returns.
// Ports: iCLOCK, inRESET (async active-low), bus (fetch_mem_responder_if.slave) carrying flush, fetch and memory signals.
module fetch_mem_responder
   import fetch_mem_responder_pkg::*;
#(
   parameter int P_RETURN_DEPTH   = 4,
   parameter int P_RETURN_DEPTH_N = 2
)(
   input  logic                        iCLOCK,
   input  logic                        inRESET,
   fetch_mem_responder_if.slave        bus
);

   localparam int               CNT_W   = P_RETURN_DEPTH_N + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(P_RETURN_DEPTH);

   logic [CNT_W-1:0] liveCnt;      // in flight, response will be kept
   logic [CNT_W-1:0] discardCnt;   // in flight, issued before a flush, response dropped
   logic [CNT_W-1:0] liveNext;
   logic [CNT_W-1:0] discardNext;
   logic [CNT_W-1:0] fifoCount;
   logic             fifoEmpty;
   logic             fifoFull;
   logic             fetchLock;
   logic             memReq;
   logic             respKeep;
   logic             respDrop;
   logic             fifoPush;
   logic             instValid;
   retBundle_t       pushBundle;
   retBundle_t       headBundle;

   // Lock looks only at held state and iMEM_BUSY; the requester gates iFETCH_REQ with it.
   assign fetchLock = bus.iMEM_BUSY || ((liveCnt + discardCnt + fifoCount) >= DEPTH_C);
   assign memReq    = bus.iFETCH_REQ && !fetchLock && !bus.iFLUSH;

   // Responses come back in issue order, so all pre-flush responses precede any kept one.
   assign respDrop  = bus.iMEM_VALID && (discardCnt != '0);
   assign respKeep  = bus.iMEM_VALID && (discardCnt == '0);
   assign fifoPush  = respKeep && !bus.iFLUSH;

   // Never present a return while locked: the fetch stage pops its address queue on valid.
   assign instValid = !fifoEmpty && !bus.iINST_LOCK && !bus.iFLUSH;

   assign pushBundle = '{pageFault: bus.iMEM_PAGEFAULT,
                         mmuFlags:  bus.iMEM_MMU_FLAGS,
                         inst:      bus.iMEM_DATA};

   always_comb begin
      liveNext    = liveCnt;
      discardNext = discardCnt;
      if (bus.iFLUSH) begin
         // Everything still in flight becomes garbage; a response this cycle retires one of them.
         discardNext = discardCnt + liveCnt - CNT_W'(bus.iMEM_VALID);
         liveNext    = '0;
      end else begin
         liveNext    = liveCnt + CNT_W'(memReq) - CNT_W'(respKeep);
         discardNext = discardCnt - CNT_W'(respDrop);
      end
   end

   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         liveCnt    <= '0;
         discardCnt <= '0;
      end else begin
         liveCnt    <= liveNext;
         discardCnt <= discardNext;
      end
   end

   fetch_mem_responder_sync_fifo #(
      .P_N       (RET_W),
      .P_DEPTH   (P_RETURN_DEPTH),
      .P_DEPTH_N (P_RETURN_DEPTH_N)
   ) returnFifo (
      .iCLOCK    (iCLOCK),
      .inRESET   (inRESET),
      .iREMOVE   (bus.iFLUSH),
      .iWR_EN    (fifoPush),
      .iWR_DATA  (pushBundle),
      .oWR_FULL  (fifoFull),
      .iRD_EN    (instValid),
      .oRD_DATA  (headBundle),
      .oRD_EMPTY (fifoEmpty),
      .oCOUNT    (fifoCount)
   );

   assign bus.oFETCH_LOCK     = fetchLock;
   assign bus.oMEM_REQ        = memReq;
   assign bus.oMEM_ADDR       = bus.iFETCH_ADDR;
   assign bus.oMEM_MMUMOD     = bus.iFETCH_MMUMOD;
   assign bus.oINST_VALID     = instValid;
   assign bus.oINST_PAGEFAULT = headBundle.pageFault;
   assign bus.oINST_MMU_FLAGS = headBundle.mmuFlags;
   assign bus.oINST           = headBundle.inst;

   // Protocol checks: a response needs an outstanding request, and credit keeps the buffer from overflowing.
   always @(posedge iCLOCK) begin
      if (inRESET && bus.iMEM_VALID) begin
         assert ((liveCnt != '0) || (discardCnt != '0))
            else $error("memory response with no request outstanding");
         assert (!(fifoPush && fifoFull))
            else $error("return buffer written while full");
      end
   end

endmodule

// File: tb/tb_fetch_mem_responder.sv
module tb_fetch_mem_responder;
   import fetch_mem_responder_pkg::*;

   logic clk;
   logic rst_n;

   fetch_mem_responder_if bus();

   fetch_mem_responder #(
      .P_RETURN_DEPTH   (4),
      .P_RETURN_DEPTH_N (2)
   ) dut (
      .iCLOCK  (clk),
      .inRESET (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: one entry per request still owed a response (1 = keep, 0 = drop),
   // plus the queue of returned bundles waiting for the fetch stage.
   bit          inflight[$];
   logic [46:0] retQ[$];
   bit          eReq;
   bit          eValid;
   int          nChecks = 0;
   int          nFail   = 0;

   typedef struct {
      bit          req;
      logic [31:0] addr;
      bit          busy;
      bit          memv;
      logic [31:0] data;
      bit          ilock;
      bit          xLock;
      bit          xReq;
      bit          xValid;
      logic [31:0] xInst;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int keepCount();
      int n = 0;
      foreach (inflight[i]) if (inflight[i]) n++;
      return n;
   endfunction

   task automatic drive(input bit req, input logic [31:0] addr, input bit busy, input bit memv,
                        input logic [31:0] data, input bit ilock, input bit flush);
      bus.iFETCH_REQ     = req;
      bus.iFETCH_ADDR    = addr;
      bus.iFETCH_MMUMOD  = mmuMod_e'(addr[1:0]);
      bus.iMEM_BUSY      = busy;
      bus.iMEM_VALID     = memv;
      bus.iMEM_DATA      = data;
      bus.iMEM_PAGEFAULT = ^data;
      bus.iMEM_MMU_FLAGS = data[13:0] ^ data[27:14];
      bus.iINST_LOCK     = ilock;
      bus.iFLUSH         = flush;
   endtask

   // Called one cycle-half after inputs change: compare DUT outputs with the model.
   task automatic settle();
      bit eLock;
      #4;
      eLock  = bus.iMEM_BUSY || ((inflight.size() + retQ.size()) >= 4);
      eReq   = bus.iFETCH_REQ && !eLock && !bus.iFLUSH;
      eValid = (retQ.size() > 0) && !bus.iINST_LOCK && !bus.iFLUSH;
      chk("fetch_lock", 64'(bus.oFETCH_LOCK), 64'(eLock));
      chk("mem_req", 64'(bus.oMEM_REQ), 64'(eReq));
      chk("inst_valid", 64'(bus.oINST_VALID), 64'(eValid));
      chk("mem_addr", 64'(bus.oMEM_ADDR), 64'(bus.iFETCH_ADDR));
      chk("mem_mmumod", 64'(bus.oMEM_MMUMOD), 64'(bus.iFETCH_MMUMOD));
      if (eValid)
         chk("inst_bundle", 64'({bus.oINST_PAGEFAULT, bus.oINST_MMU_FLAGS, bus.oINST}), 64'(retQ[0]));
      chk("live_cnt", 64'(dut.liveCnt), 64'(keepCount()));
      chk("discard_cnt", 64'(dut.discardCnt), 64'(inflight.size() - keepCount()));
   endtask

   // Clock edge: advance the model with the inputs that were present at the edge.
   task automatic advance();
      bit          flush;
      bit          memv;
      bit          k;
      logic [46:0] b;
      @(posedge clk);
      flush = bus.iFLUSH;
      memv  = bus.iMEM_VALID;
      b     = {bus.iMEM_PAGEFAULT, bus.iMEM_MMU_FLAGS, bus.iMEM_DATA};
      if (flush) begin
         retQ.delete();
         foreach (inflight[i]) inflight[i] = 1'b0;
         if (memv && inflight.size() > 0) void'(inflight.pop_front());
      end else begin
         if (eValid) void'(retQ.pop_front());
         if (memv && inflight.size() > 0) begin
            k = inflight.pop_front();
            if (k) retQ.push_back(b);
         end
         if (eReq) inflight.push_back(1'b1);
      end
      #1;
   endtask

   task automatic cyc(input bit req, input logic [31:0] addr, input bit memv,
                      input logic [31:0] data, input bit ilock, input bit flush);
      drive(req, addr, 1'b0, memv, data, ilock, flush);
      settle();
      advance();
   endtask

   function automatic vec_t mk(bit req, logic [31:0] addr, bit busy, bit memv, logic [31:0] data,
                               bit ilock, bit lk, bit rq, bit vl, logic [31:0] inst);
      vec_t v;
      v.req = req; v.addr = addr; v.busy = busy; v.memv = memv; v.data = data; v.ilock = ilock;
      v.xLock = lk; v.xReq = rq; v.xValid = vl; v.xInst = inst;
      return v;
   endfunction

   initial begin
      bit mv;

      // req addr busy memv data ilock | lock req valid inst
      tbl.push_back(mk(0, 32'h0,  0, 0, 32'h0,        0, 0, 0, 0, 32'h0));
      tbl.push_back(mk(1, 32'h10, 0, 0, 32'h0,        0, 0, 1, 0, 32'h0));
      tbl.push_back(mk(0, 32'h0,  0, 0, 32'h0,        0, 0, 0, 0, 32'h0));
      tbl.push_back(mk(0, 32'h0,  0, 0, 32'h0,        0, 0, 0, 0, 32'h0));
      tbl.push_back(mk(0, 32'h0,  0, 1, 32'hDEADBEEF, 0, 0, 0, 0, 32'h0));
      tbl.push_back(mk(0, 32'h0,  0, 0, 32'h0,        0, 0, 0, 1, 32'hDEADBEEF));
      tbl.push_back(mk(0, 32'h0,  0, 0, 32'h0,        0, 0, 0, 0, 32'h0));
      tbl.push_back(mk(1, 32'h20, 0, 0, 32'h0,        0, 0, 1, 0, 32'h0));
      tbl.push_back(mk(1, 32'h24, 0, 0, 32'h0,        0, 0, 1, 0, 32'h0));
      tbl.push_back(mk(1, 32'h28, 0, 0, 32'h0,        0, 0, 1, 0, 32'h0));
      tbl.push_back(mk(1, 32'h2C, 0, 0, 32'h0,        0, 0, 1, 0, 32'h0));
      tbl.push_back(mk(1, 32'h30, 0, 0, 32'h0,        0, 1, 0, 0, 32'h0));
      tbl.push_back(mk(1, 32'h30, 0, 1, 32'h11111111, 0, 1, 0, 0, 32'h0));
      tbl.push_back(mk(0, 32'h0,  0, 0, 32'h0,        0, 1, 0, 1, 32'h11111111));
      tbl.push_back(mk(1, 32'h30, 0, 0, 32'h0,        0, 0, 1, 0, 32'h0));
      tbl.push_back(mk(0, 32'h0,  0, 1, 32'h22222222, 1, 1, 0, 0, 32'h0));
      tbl.push_back(mk(0, 32'h0,  0, 1, 32'h33333333, 1, 1, 0, 0, 32'h0));
      tbl.push_back(mk(0, 32'h0,  0, 1, 32'h44444444, 1, 1, 0, 0, 32'h0));
      tbl.push_back(mk(0, 32'h0,  0, 1, 32'h55555555, 1, 1, 0, 0, 32'h0));
      tbl.push_back(mk(0, 32'h0,  0, 0, 32'h0,        0, 1, 0, 1, 32'h22222222));
      tbl.push_back(mk(0, 32'h0,  0, 0, 32'h0,        0, 0, 0, 1, 32'h33333333));
      tbl.push_back(mk(0, 32'h0,  0, 0, 32'h0,        0, 0, 0, 1, 32'h44444444));
      tbl.push_back(mk(0, 32'h0,  0, 0, 32'h0,        0, 0, 0, 1, 32'h55555555));
      tbl.push_back(mk(0, 32'h0,  0, 0, 32'h0,        0, 0, 0, 0, 32'h0));
      tbl.push_back(mk(1, 32'h40, 1, 0, 32'h0,        0, 1, 0, 0, 32'h0));
      tbl.push_back(mk(0, 32'h0,  0, 0, 32'h0,        0, 0, 0, 0, 32'h0));

      // Reset state
      rst_n = 1'b0;
      drive(0, 32'h0, 0, 0, 32'h0, 0, 0);
      #12;
      chk("rst_inst_valid", 64'(bus.oINST_VALID), 64'd0);
      chk("rst_mem_req", 64'(bus.oMEM_REQ), 64'd0);
      chk("rst_fetch_lock", 64'(bus.oFETCH_LOCK), 64'd0);
      chk("rst_live", 64'(dut.liveCnt), 64'd0);
      chk("rst_fifo", 64'(dut.fifoCount), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Table: single fetch, credit limit, consumer stall, busy
      foreach (tbl[i]) begin
         drive(tbl[i].req, tbl[i].addr, tbl[i].busy, tbl[i].memv, tbl[i].data, tbl[i].ilock, 1'b0);
         settle();
         chk($sformatf("tbl%0d_lock", i), 64'(bus.oFETCH_LOCK), 64'(tbl[i].xLock));
         chk($sformatf("tbl%0d_req", i), 64'(bus.oMEM_REQ), 64'(tbl[i].xReq));
         chk($sformatf("tbl%0d_valid", i), 64'(bus.oINST_VALID), 64'(tbl[i].xValid));
         if (tbl[i].xValid)
            chk($sformatf("tbl%0d_inst", i), 64'(bus.oINST), 64'(tbl[i].xInst));
         advance();
      end

      // Flush with 2 in flight and 1 buffered
      cyc(1, 32'h200, 0, 32'h0, 0, 0);
      cyc(1, 32'h204, 0, 32'h0, 0, 0);
      cyc(1, 32'h208, 0, 32'h0, 0, 0);
      cyc(0, 32'h0, 1, 32'hAAAA0001, 1, 0);
      drive(1, 32'h300, 0, 0, 32'h0, 0, 1);
      settle();
      chk("flush_req_blocked", 64'(bus.oMEM_REQ), 64'd0);
      chk("flush_valid_blocked", 64'(bus.oINST_VALID), 64'd0);
      advance();
      chk("flush_discard", 64'(dut.discardCnt), 64'd2);
      chk("flush_fifo_empty", 64'(dut.fifoCount), 64'd0);
      drive(1, 32'h100, 0, 0, 32'h0, 0, 0);
      settle();
      chk("postflush_req", 64'(bus.oMEM_REQ), 64'd1);
      chk("postflush_addr", 64'(bus.oMEM_ADDR), 64'h100);
      advance();
      cyc(0, 32'h0, 1, 32'hBBBB0001, 0, 0);
      chk("drop1_valid", 64'(bus.oINST_VALID), 64'd0);
      cyc(0, 32'h0, 1, 32'hBBBB0002, 0, 0);
      chk("drop2_valid", 64'(bus.oINST_VALID), 64'd0);
      cyc(0, 32'h0, 1, 32'hC0DE0100, 0, 0);
      drive(0, 32'h0, 0, 0, 32'h0, 0, 0);
      settle();
      chk("postflush_first_valid", 64'(bus.oINST_VALID), 64'd1);
      chk("postflush_first_inst", 64'(bus.oINST), 64'hC0DE0100);
      advance();

      // Flush coincident with response and request
      cyc(1, 32'h500, 0, 32'h0, 0, 0);
      cyc(1, 32'h504, 0, 32'h0, 0, 0);
      drive(1, 32'h508, 0, 1, 32'hEEEE0001, 0, 1);
      settle();
      chk("coinc_req_blocked", 64'(bus.oMEM_REQ), 64'd0);
      advance();
      chk("coinc_discard", 64'(dut.discardCnt), 64'd1);
      chk("coinc_live", 64'(dut.liveCnt), 64'd0);
      cyc(0, 32'h0, 1, 32'hEEEE0002, 0, 0);
      cyc(0, 32'h0, 0, 32'h0, 0, 0);
      chk("coinc_drained", 64'(dut.discardCnt), 64'd0);

      // Back-to-back flushes accumulate
      cyc(1, 32'h600, 0, 32'h0, 0, 0);
      cyc(0, 32'h0, 0, 32'h0, 0, 1);
      cyc(1, 32'h604, 0, 32'h0, 0, 0);
      cyc(0, 32'h0, 0, 32'h0, 0, 1);
      cyc(0, 32'h0, 0, 32'h0, 0, 1);
      chk("b2b_discard", 64'(dut.discardCnt), 64'd2);
      cyc(0, 32'h0, 1, 32'hF0F00001, 0, 0);
      cyc(0, 32'h0, 1, 32'hF0F00002, 0, 0);
      cyc(0, 32'h0, 0, 32'h0, 0, 0);

      // Async reset mid-burst with 2 buffered
      cyc(1, 32'h400, 0, 32'h0, 1, 0);
      cyc(1, 32'h404, 0, 32'h0, 1, 0);
      cyc(0, 32'h0, 1, 32'h00000401, 1, 0);
      cyc(0, 32'h0, 1, 32'h00000402, 1, 0);
      #2;
      rst_n = 1'b0;
      drive(0, 32'h0, 0, 0, 32'h0, 0, 0);
      #1;
      chk("arst_valid", 64'(bus.oINST_VALID), 64'd0);
      chk("arst_live", 64'(dut.liveCnt), 64'd0);
      chk("arst_discard", 64'(dut.discardCnt), 64'd0);
      chk("arst_fifo", 64'(dut.fifoCount), 64'd0);
      chk("arst_lock_idle", 64'(bus.oFETCH_LOCK), 64'd0);
      bus.iMEM_BUSY = 1'b1;
      #1;
      chk("arst_lock_busy", 64'(bus.oFETCH_LOCK), 64'd1);
      bus.iMEM_BUSY = 1'b0;
      inflight.delete();
      retQ.delete();
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         mv = (inflight.size() > 0) && ($urandom_range(2) == 0);
         drive(1'($urandom_range(1)), $urandom, ($urandom_range(7) == 0), mv, $urandom,
               ($urandom_range(3) == 0), ($urandom_range(31) == 0));
         settle();
         advance();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
